sr_pulse_ctrl: RTL and testbench
================================

SR_PULSE_CTRL -- requirements
Module: sr_pulse_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive stable synchronized samples (>=2) required to accept a new button level.
REQ-003 Parameter PW, default 2: width in cycles (>=1) of each s/r pulse.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sb  input  1  raw set push-button, asynchronous, may bounce.
REQ-007 rb  input  1  raw reset push-button, asynchronous, may bounce.
REQ-008 q  input  1  feedback from the downstream NOR SR latch output.
REQ-009 s  output  1  set drive to the latch, registered.
REQ-010 r  output  1  reset drive to the latch, registered.
REQ-011 busy  output  1  high while a pulse or check is in progress.
REQ-012 err  output  1  sticky latch-response mismatch flag.

Function
REQ-013 sb and rb SHALL each pass through a two-flop synchronizer before any other use.
REQ-014 Each synchronized input SHALL have its own debounce counter; the debounced level changes only after DEB_CYCLES consecutive cycles in which the synchronized sample differs from it; any agreeing sample clears the counter.
REQ-015 A 0->1 transition of debounced sb SHALL raise a set request, and of debounced rb a reset request, each for one cycle.
REQ-016 The FSM SHALL have states IDLE, SET, RST and CHK.
REQ-017 IDLE: on a reset request go to RST; else on a set request go to SET; else stay.
REQ-018 When set and reset requests occur in the same cycle, reset SHALL win and the set request SHALL be dropped.
REQ-019 SET drives s=1 and RST drives r=1 for exactly PW cycles; then the FSM goes to CHK.
REQ-020 CHK lasts one cycle; s=r=0; err is set if q!=1 after SET or q!=0 after RST; then IDLE.
REQ-021 Requests arriving while busy=1 SHALL be discarded, not queued.
REQ-022 s and r SHALL never be high in the same cycle, including across reset.
REQ-023 busy = 1 in SET, RST and CHK; 0 in IDLE.
REQ-024 Latency: s (or r) SHALL rise DEB_CYCLES+3 rising edges after the edge that first samples a stable high on sb (or rb).
REQ-025 Holding a button high SHALL produce exactly one pulse; a new pulse needs a debounced release and press.

Reset
REQ-026 While rst=1 the block SHALL reset to: FSM IDLE, s=0, r=0, busy=0, err=0, debounced levels 0, counters 0, synchronizers 0.
REQ-027 Reset asserted mid-pulse SHALL drop s/r on the next rising edge and abandon the pending check.
REQ-028 err SHALL clear only through rst.

Configuration
REQ-029 Macro SR_CHECK_EN: defined: CHK state and err behave per REQ-020; undefined: CHK is omitted, SET/RST return directly to IDLE, err ties to 0, and q is unused.

Verification
REQ-030 DEB_CYCLES=4, PW=2: sb held high from cycle 0 -> s=1 on edges 7-8, busy=1 on edges 7-9, s=0 afterward.
REQ-031 sb bounces 1,0,1,0 (2-cycle highs), then stays low -> s never asserts and busy stays 0.
REQ-032 sb and rb rise in the same cycle and stay high -> only r pulses for 2 cycles; s stays 0 throughout.
REQ-033 With SR_CHECK_EN, q held 0 during a set pulse -> err=1 after CHK and stays 1 until rst; without the macro, err stays 0.
REQ-034 rst asserted during the second cycle of an s pulse -> s=0, busy=0 on the next edge; no err.
REQ-035 rb pressed while busy from a set pulse -> it is ignored, with no r pulse after the set completes.

Source files
------------

// File: rtl/sr_pulse_ctrl.sv
// sr_pulse_ctrl: debounced set/reset push-buttons drive fixed-width s/r pulses into a NOR SR latch
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   sb   : raw set button (asynchronous, bouncing)
//   rb   : raw reset button (asynchronous, bouncing)
//   q    : latch output feedback (used only with SR_CHECK_EN)
//   s, r : registered set/reset drives, PW cycles wide, never both high
//   busy : high while a pulse or response check is in progress
//   err  : sticky latch-response mismatch (SR_CHECK_EN), else tied 0
// Define SR_CHECK_EN to add the one-cycle CHK state that compares q against the pulse just issued.
module sr_pulse_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int PW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sb,
  input  logic rb,
  input  logic q,
  output logic s,
  output logic r,
  output logic busy,
  output logic err
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int PWW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PWW-1:0] PW_LAST = PWW'(PW - 1);
`ifdef SR_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SET = 2'd1, RST = 2'd2, CHK = 2'd3} state_t;
  localparam state_t DONE = CHK;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SET = 2'd1, RST = 2'd2} state_t;
  localparam state_t DONE = IDLE;
`endif
  // bit 0 carries the set button, bit 1 the reset button
  logic [1:0] s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, prev_q, prev_d, req_q, req_d;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  logic [PWW-1:0] pw_q, pw_d;
  logic pw_last;
  logic s_q, s_d, r_q, r_d, busy_q, busy_d;
  always_comb begin
    s1_d = {rb, sb};
    s2_d = s1_q;
    prev_d = deb_q;
    // registering the edge adds the cycle that puts the pulse DEB_CYCLES+3 edges after the first sample
    req_d = deb_q & ~prev_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (s2_q[i] == deb_q[i] || cnt_q[i] == DEB_LAST) ? '0 : cnt_q[i] + 1'b1;
      deb_d[i] = (s2_q[i] != deb_q[i] && cnt_q[i] == DEB_LAST) ? s2_q[i] : deb_q[i];
    end
  end
  always_comb begin
    state_d = state_q;
    pw_d = '0;
    pw_last = (pw_q == PW_LAST);
    case (state_q)
      // reset request wins; requests seen outside IDLE are simply lost
      IDLE: state_d = req_q[1] ? RST : (req_q[0] ? SET : IDLE);
      SET, RST: begin
        pw_d = pw_last ? '0 : pw_q + 1'b1;
        state_d = pw_last ? DONE : state_q;
      end
      default: state_d = IDLE;
    endcase
    s_d = (state_d == SET);
    r_d = (state_d == RST);
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      deb_q <= '0;
      prev_q <= '0;
      req_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      pw_q <= '0;
      s_q <= 1'b0;
      r_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      deb_q <= deb_d;
      prev_q <= prev_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      pw_q <= pw_d;
      s_q <= s_d;
      r_q <= r_d;
      busy_q <= busy_d;
    end
  end
  assign s = s_q;
  assign r = r_q;
  assign busy = busy_q;
`ifdef SR_CHECK_EN
  logic err_q, err_d, chk_set_q, chk_set_d;
  always_comb begin
    // during CHK this remembers whether the finished pulse was a set
    chk_set_d = (state_q == SET);
    err_d = err_q | (state_q == CHK && (chk_set_q ? !q : q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      chk_set_q <= 1'b0;
    end else begin
      err_q <= err_d;
      chk_set_q <= chk_set_d;
    end
  end
  assign err = err_q;
`else
  logic unused_q;
  assign unused_q = q;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// tb_sr_pulse_ctrl: scoreboard bench with a timing-arithmetic reference model for sr_pulse_ctrl
module tb_sr_pulse_ctrl;
  localparam int DEB = 4;
  localparam int PW = 2;
`ifdef SR_CHECK_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, sb = 1'b0, rb = 1'b0, q = 1'b0;
  logic s, r, busy, err;
  sr_pulse_ctrl #(.DEB_CYCLES(DEB), .PW(PW)) dut (
    .clk(clk), .rst(rst), .sb(sb), .rb(rb), .q(q),
    .s(s), .r(r), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {bit kind; int start;} pulse_t;
  typedef struct {bit kind; int edge_n;} chk_t;
  pulse_t exp_q[$];
  chk_t chk_q[$];
  int checks = 0, errors = 0, ecount = 0;
  bit exp_busy = 0, exp_err = 0, lat = 0, qgood = 1, qval = 0;
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, ecount);
    end
  endtask
  // environment latch: follows the pulses the model expects, or a forced value to provoke err
  always @(negedge clk) q = qgood ? lat : qval;
  // reference model: each pulse is placed by edge arithmetic from the button history
  bit d1[2], d2[2], deb[2], rose[2], raw[2];
  int run[2];
  bit cur_v = 0, cur_k = 0;
  int cur_s = 0, cur_f = 0;
  always @(posedge clk) begin : model
    bit sy;
    ecount++;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        d1[i] = 0; d2[i] = 0; deb[i] = 0; run[i] = 0;
      end
      cur_v = 0; exp_busy = 0; exp_err = 0; lat = 0;
      exp_q.delete(); chk_q.delete();
    end else begin
      raw[0] = sb; raw[1] = rb;
      for (int i = 0; i < 2; i++) begin
        sy = d2[i]; d2[i] = d1[i]; d1[i] = raw[i]; rose[i] = 0;
        if (sy != deb[i]) begin
          run[i]++;
          if (run[i] == DEB) begin deb[i] = sy; run[i] = 0; rose[i] = sy; end
        end else run[i] = 0;
      end
      if (chk_q.size() > 0 && chk_q[0].edge_n == ecount) begin
        if (chk_q[0].kind ? !q : q) exp_err = 1;
        void'(chk_q.pop_front());
      end
      if (cur_v && ecount == cur_s) lat = cur_k;
      exp_busy = cur_v && ecount >= cur_s && ecount < cur_f;
      if ((rose[0] || rose[1]) && (!cur_v || ecount + 1 >= cur_f)) begin
        cur_v = 1; cur_k = !rose[1]; cur_s = ecount + 2; cur_f = cur_s + PW + CK;
        exp_q.push_back('{cur_k, cur_s});
        if (CK == 1) chk_q.push_back('{cur_k, cur_s + PW + 1});
      end
    end
  end
  // monitor: pops the scoreboard when a pulse appears and checks its shape and status outputs
  bit prev_s = 0, prev_r = 0;
  int wcnt = 0;
  always @(posedge clk) begin : monitor
    pulse_t p;
    #1;
    if (rst) begin
      check("rst_s", s, 0); check("rst_r", r, 0);
      check("rst_busy", busy, 0); check("rst_err", err, 0);
      prev_s = 0; prev_r = 0; wcnt = 0;
    end else begin
      check("s_r_exclusive", s & r, 0);
      check("busy", busy, exp_busy);
      check("err", err, exp_err);
      if ((s && !prev_s) || (r && !prev_r)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got s=%0d r=%0d expected none at edge %0d", s, r, ecount);
        end else begin
          p = exp_q.pop_front();
          check("pulse_kind_is_set", s, p.kind);
          check("pulse_start_edge", ecount, p.start);
        end
      end
      if (s || r) wcnt++;
      else if (prev_s || prev_r) begin
        check("pulse_width", wcnt, PW);
        wcnt = 0;
      end
      prev_s = s; prev_r = r;
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_set_timed();
    int e0;
    bit seen;
    e0 = ecount; sb = 1; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (s) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL s_timeout: got no s pulse expected one within 40 cycles");
    end else check("s_latency", ecount - (e0 + 1), DEB + 3);
  endtask
  initial begin
    cyc(3); rst = 0;
    press_set_timed(); cyc(20); sb = 0; cyc(20);
    for (int k = 0; k < 2; k++) begin sb = 1; cyc(2); sb = 0; cyc(2); end
    cyc(20);
    sb = 1; rb = 1; cyc(20); sb = 0; rb = 0; cyc(20);
    sb = 1; cyc(1); rb = 1; cyc(20); sb = 0; rb = 0; cyc(20);
    qgood = 0; qval = 0;
    press_set_timed(); cyc(1); rst = 1; cyc(1); rst = 0; sb = 0; qgood = 1; cyc(20);
    qgood = 0; qval = 0;
    sb = 1; cyc(20); sb = 0; cyc(20); qgood = 1;
    rb = 1; cyc(20); rb = 0; cyc(20);
    rst = 1; cyc(2); rst = 0; cyc(5);
    repeat (300) begin
      sb = 1'($urandom); rb = 1'($urandom);
      qgood = ($urandom_range(0, 9) != 0); qval = 1'($urandom);
      if ($urandom_range(0, 60) == 0) begin rst = 1; cyc(1); rst = 0; end
      cyc($urandom_range(1, 12));
    end
    sb = 0; rb = 0; qgood = 1; cyc(30);
    check("pending_pulses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish expected finish within 2ms");
    $fatal(1, "timeout");
  end
endmodule
